// File: rtl/jtbubl_mailbox.sv
// jtbubl_mailbox: main<->sound command FIFOs with status, NMI control; define MAILBOX_IRQ_EN to add main_irq_n
module jtbubl_mailbox #(
    parameter int DW      = 8,
    parameter int AW      = 2,
    parameter bit NMI_RST = 1'b0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] main_din,
    input  logic          main_wr,
    input  logic          main_rd,
    output logic [DW-1:0] main_dout,
    output logic          main_empty,
    output logic          main_full,
    input  logic          snd_cs,
    input  logic [1:0]    snd_addr,
    input  logic          snd_rd_n,
    input  logic          snd_wr_n,
    input  logic [DW-1:0] snd_din,
    output logic [DW-1:0] snd_dout,
    output logic          nmi_n
`ifdef MAILBOX_IRQ_EN
    ,output logic         main_irq_n
`endif
);
    localparam int DEPTH = 1 << AW;
    localparam int PW = AW > 0 ? AW : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return AW > 0 ? p + 1'b1 : '0;
    endfunction

    logic [DW-1:0] m2s_mem [DEPTH];
    logic [DW-1:0] s2m_mem [DEPTH];
    logic [PW-1:0] m2s_wp, m2s_rp, s2m_wp, s2m_rp;
    logic [AW:0]   m2s_cnt, s2m_cnt;
    logic          m2s_ovf, s2m_ovf, nmi_en, rd_d, wr_d;
    logic          rd_lvl, wr_lvl, rd_act, wr_act;
    logic          m2s_ne, s2m_ne, m2s_full, s2m_full;
    logic          m2s_pop, m2s_push, m2s_flush, m2s_ovf_set;
    logic          s2m_pop, s2m_push, s2m_ovf_set, ovf_clr;
    logic [DW-1:0] stat, rsel;

    always_comb begin
        rd_lvl      = snd_cs & ~snd_rd_n;
        wr_lvl      = snd_cs & ~snd_wr_n;
        rd_act      = rd_lvl & ~rd_d;
        wr_act      = wr_lvl & ~wr_d;
        m2s_ne      = m2s_cnt != '0;
        s2m_ne      = s2m_cnt != '0;
        m2s_full    = m2s_cnt == FULL_CNT;
        s2m_full    = s2m_cnt == FULL_CNT;
        m2s_pop     = rd_act & (snd_addr == 2'd0) & m2s_ne;
        m2s_flush   = wr_act & (snd_addr == 2'd3);
        // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
        m2s_push    = main_wr & (~m2s_full | m2s_pop) & ~m2s_flush;
        m2s_ovf_set = main_wr & m2s_full & ~m2s_pop & ~m2s_flush;
        s2m_pop     = main_rd & s2m_ne;
        s2m_push    = wr_act & (snd_addr == 2'd0) & (~s2m_full | s2m_pop);
        s2m_ovf_set = wr_act & (snd_addr == 2'd0) & s2m_full & ~s2m_pop;
        ovf_clr     = rd_act & (snd_addr == 2'd1);
        stat        = '1;
        stat[4:0]   = {nmi_en, s2m_ovf, m2s_ovf, s2m_full, m2s_ne};
        rsel        = snd_addr == 2'd0 ? (m2s_ne ? m2s_mem[m2s_rp] : '1) :
                      snd_addr == 2'd1 ? stat : '1;
        main_dout   = s2m_ne ? s2m_mem[s2m_rp] : '0;
        main_empty  = ~s2m_ne;
        main_full   = m2s_full;
    end

    always_ff @(posedge clk) begin
        if (m2s_push) m2s_mem[m2s_wp] <= main_din;
        if (s2m_push) s2m_mem[s2m_wp] <= snd_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2s_wp   <= '0;
            m2s_rp   <= '0;
            m2s_cnt  <= '0;
            s2m_wp   <= '0;
            s2m_rp   <= '0;
            s2m_cnt  <= '0;
            m2s_ovf  <= 1'b0;
            s2m_ovf  <= 1'b0;
            nmi_en   <= NMI_RST;
            rd_d     <= 1'b0;
            wr_d     <= 1'b0;
            snd_dout <= '1;
            nmi_n    <= 1'b1;
`ifdef MAILBOX_IRQ_EN
            main_irq_n <= 1'b1;
`endif
        end else begin
            rd_d <= rd_lvl;
            wr_d <= wr_lvl;
            if (m2s_flush) begin
                m2s_wp  <= '0;
                m2s_rp  <= '0;
                m2s_cnt <= '0;
            end else begin
                if (m2s_push) m2s_wp <= nxt(m2s_wp);
                if (m2s_pop) m2s_rp <= nxt(m2s_rp);
                m2s_cnt <= m2s_cnt + (AW+1)'(m2s_push) - (AW+1)'(m2s_pop);
            end
            if (s2m_push) s2m_wp <= nxt(s2m_wp);
            if (s2m_pop) s2m_rp <= nxt(s2m_rp);
            s2m_cnt <= s2m_cnt + (AW+1)'(s2m_push) - (AW+1)'(s2m_pop);
            m2s_ovf <= m2s_ovf_set | (m2s_ovf & ~ovf_clr);
            s2m_ovf <= s2m_ovf_set | (s2m_ovf & ~ovf_clr);
            if (wr_act && snd_addr == 2'd1) nmi_en <= 1'b1;
            if (wr_act && snd_addr == 2'd2) nmi_en <= 1'b0;
            // value is latched at the start of the access and held until the strobe ends
            snd_dout <= rd_act ? rsel : rd_lvl ? snd_dout : '1;
            nmi_n    <= ~(nmi_en & m2s_ne);
`ifdef MAILBOX_IRQ_EN
            main_irq_n <= ~s2m_ne;
`endif
        end
    end
endmodule

// File: tb/tb_jtbubl_mailbox.sv
// tb_jtbubl_mailbox: directed and random checks of jtbubl_mailbox against a queue-based model
module tb_jtbubl_mailbox;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] main_din = '0;
    logic       main_wr = 1'b0, main_rd = 1'b0;
    logic [7:0] main_dout;
    logic       main_empty, main_full;
    logic       snd_cs = 1'b0;
    logic [1:0] snd_addr = '0;
    logic       snd_rd_n = 1'b1, snd_wr_n = 1'b1;
    logic [7:0] snd_din = '0;
    logic [7:0] snd_dout;
    logic       nmi_n;

    jtbubl_mailbox #(.DW(8), .AW(2), .NMI_RST(1'b0)) dut (
        .clk(clk), .rst(rst), .main_din(main_din), .main_wr(main_wr), .main_rd(main_rd),
        .main_dout(main_dout), .main_empty(main_empty), .main_full(main_full),
        .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_rd_n(snd_rd_n), .snd_wr_n(snd_wr_n),
        .snd_din(snd_din), .snd_dout(snd_dout), .nmi_n(nmi_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] qm[$];
    logic [7:0] qs[$];
    logic ovf_m = 0, ovf_s = 0, en = 0, prl = 0, pwl = 0;
    logic nmi_exp = 1;
    logic [7:0] sdout_exp = 8'hFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mstat();
        return {3'b111, en, ovf_s, ovf_m, qs.size() == 4, qm.size() != 0};
    endfunction

    task automatic model_reset();
        qm.delete();
        qs.delete();
        ovf_m = 0; ovf_s = 0; en = 0; prl = 0; pwl = 0;
        nmi_exp = 1; sdout_exp = 8'hFF;
    endtask

    task automatic step(input logic wr, input logic [7:0] din, input logic rd, input logic cs,
                        input logic rd_n, input logic wr_n, input logic [1:0] addr, input logic [7:0] sdin);
        logic rl, wl, ra, wa, pop_m, pop_s, full_m, full_s, set_m, set_s, clr, chk_sd;
        main_wr = wr; main_din = din; main_rd = rd;
        snd_cs = cs; snd_rd_n = rd_n; snd_wr_n = wr_n; snd_addr = addr; snd_din = sdin;
        rl = cs & ~rd_n; wl = cs & ~wr_n;
        ra = rl & ~prl;  wa = wl & ~pwl;
        prl = rl; pwl = wl;
        nmi_exp = !(en && qm.size() != 0);
        if (ra) sdout_exp = addr == 0 ? (qm.size() != 0 ? qm[0] : 8'hFF) : addr == 1 ? mstat() : 8'hFF;
        else if (!rl) sdout_exp = 8'hFF;
        chk_sd = !rl || ra;
        clr = ra && addr == 1;
        full_m = qm.size() == 4;
        full_s = qs.size() == 4;
        pop_m = ra && addr == 0 && qm.size() != 0;
        pop_s = rd && qs.size() != 0;
        set_m = 0; set_s = 0;
        if (wa && addr == 3) qm.delete();
        else begin
            if (pop_m) void'(qm.pop_front());
            if (wr) begin
                if (full_m && !pop_m) set_m = 1;
                else qm.push_back(din);
            end
        end
        if (pop_s) void'(qs.pop_front());
        if (wa && addr == 0) begin
            if (full_s && !pop_s) set_s = 1;
            else qs.push_back(sdin);
        end
        ovf_m = set_m || (ovf_m && !clr);
        ovf_s = set_s || (ovf_s && !clr);
        if (wa && addr == 1) en = 1;
        if (wa && addr == 2) en = 0;
        @(posedge clk); #1;
        if (chk_sd) chk("snd_dout", snd_dout, sdout_exp);
        chk("nmi_n", nmi_n, nmi_exp);
        chk("main_empty", main_empty, qs.size() == 0);
        chk("main_full", main_full, qm.size() == 4);
        chk("main_dout", main_dout, qs.size() != 0 ? qs[0] : 8'h00);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic mwr(input logic [7:0] d);
        step(1, d, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic srd(input logic [1:0] a, output logic [7:0] v);
        step(0, 0, 0, 1, 0, 1, a, 0);
        v = snd_dout;
        idle();
    endtask

    task automatic swr(input logic [1:0] a, input logic [7:0] d);
        step(0, 0, 0, 1, 1, 0, a, d);
        idle();
    endtask

    initial begin
        logic [7:0] v;
        logic r_wr, r_rd, r_cs, r_rdn, r_wrn;
        logic [1:0] r_a;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_snd_dout", snd_dout, 8'hFF);
        chk("rst_nmi_n", nmi_n, 1'b1);
        chk("rst_empty", main_empty, 1'b1);
        chk("rst_full", main_full, 1'b0);
        chk("rst_main_dout", main_dout, 8'h00);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        srd(1, v); chk("status_after_reset", v, 8'hE0);

        mwr(8'h11); mwr(8'h22); mwr(8'h33); mwr(8'h44); mwr(8'h55);
        chk("full_after_5", main_full, 1'b1);
        srd(1, v); chk("status_ovf", v, 8'hE5);
        srd(0, v); chk("pop1", v, 8'h11);
        srd(0, v); chk("pop2", v, 8'h22);
        srd(0, v); chk("pop3", v, 8'h33);
        srd(0, v); chk("pop4", v, 8'h44);
        srd(0, v); chk("pop_empty", v, 8'hFF);
        srd(1, v); chk("status_cleared", v, 8'hE0);

        swr(1, 0);
        mwr(8'hA5);
        chk("nmi_not_yet", nmi_n, 1'b1);
        idle();
        chk("nmi_low", nmi_n, 1'b0);
        srd(0, v); chk("pop_a5", v, 8'hA5);
        chk("nmi_release", nmi_n, 1'b1);
        swr(2, 0);
        mwr(8'h5A); idle(); idle();
        chk("nmi_disabled", nmi_n, 1'b1);
        swr(3, 0);

        mwr(8'h01); mwr(8'h02);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        chk("held_first", snd_dout, 8'h01);
        repeat (4) step(0, 0, 0, 1, 0, 1, 0, 0);
        idle();
        srd(0, v); chk("held_one_pop", v, 8'h02);

        mwr(8'h10); mwr(8'h20); mwr(8'h30); mwr(8'h40);
        step(1, 8'h99, 0, 1, 0, 1, 0, 0);
        chk("simul_head", snd_dout, 8'h10);
        chk("simul_full", main_full, 1'b1);
        idle();
        srd(1, v); chk("simul_no_ovf", v, 8'hE1);
        swr(3, 0);
        swr(0, 8'h7E);
        chk("s2m_head", main_dout, 8'h7E);
        step(0, 0, 1, 0, 1, 1, 0, 0);
        chk("s2m_popped", main_dout, 8'h00);
        chk("s2m_empty", main_empty, 1'b1);

        for (int i = 0; i < 600; i++) begin
            r_cs = 1'($urandom_range(0, 1));
            r_rdn = 1'($urandom_range(0, 1));
            r_wrn = 1'($urandom_range(0, 1));
            r_a = 2'($urandom_range(0, 3));
            r_rd = $urandom_range(0, 9) < 3;
            r_wr = (r_cs && !r_wrn && r_a == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            step(r_wr, 8'($urandom), r_rd, r_cs, r_rdn, r_wrn, r_a, 8'($urandom));
        end

        idle();
        swr(3, 0);
        swr(1, 0);
        mwr(8'hC1); mwr(8'hC2);
        swr(0, 8'hD1); swr(0, 8'hD2);
        chk("pre_rst_nmi", nmi_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_nmi_n", nmi_n, 1'b1);
        chk("arst_empty", main_empty, 1'b1);
        chk("arst_full", main_full, 1'b0);
        chk("arst_main_dout", main_dout, 8'h00);
        chk("arst_snd_dout", snd_dout, 8'hFF);
        model_reset();
        #3 rst = 1'b0;
        idle();
        srd(1, v); chk("status_post_arst", v, 8'hE0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
